// File: rtl/host_spi_master.sv
// host_spi_master: mode-0, 16-bit MSB-first SPI initiator for the CPU's local peripherals.
// One word per start strobe; an optional CS hold joins consecutive words into one frame.
module host_spi_master #(
    parameter int unsigned  CLK_DIV = 4,
    parameter int unsigned  NCS     = 2,
    localparam int unsigned CSW     = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [15:0]    tx_data,
    input  logic [CSW-1:0] cs_sel,
    input  logic           hold,
    output logic           busy,
    output logic           done,
    output logic [15:0]    rx_data,
    output logic           spi_sclk,
    output logic [NCS-1:0] spi_cs_n,
    output logic           spi_mosi,
    input  logic           spi_miso
);

    localparam int unsigned   DW       = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HELD  = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_SETUP = 3'd3;
    localparam logic [2:0] S_HIGH  = 3'd4;
    localparam logic [2:0] S_LOW   = 3'd5;

    logic [2:0]     state;
    logic [2:0]     state_nxt;
    logic [DW-1:0]  div_cnt;
    logic [3:0]     bit_cnt;
    logic [15:0]    tx_sr;
    logic [15:0]    rx_sr;
    logic [CSW-1:0] cur_cs;
    logic           cur_hold;

    logic           accept_c;
    logic           phase_end_c;
    logic           active_c;
    logic           word_end_c;
    logic [NCS-1:0] cs_n_c;

    // Next-state and control decode; outputs are registered from this one cycle later.
    always_comb begin
        state_nxt   = state;
        phase_end_c = (div_cnt == '0);
        accept_c    = start && !busy && (state == S_IDLE || state == S_HELD);
        active_c    = (state == S_SETUP) || (state == S_HIGH) || (state == S_LOW);
        word_end_c  = busy && (state == S_IDLE || state == S_HELD);
        cs_n_c      = '1;
        for (int i = 0; i < NCS; i++) begin
            cs_n_c[i] = !((active_c || state == S_HELD) && cur_cs == CSW'(i));
        end

        case (state)
            S_IDLE:  if (accept_c) state_nxt = S_SETUP;
            S_HELD:  if (accept_c) state_nxt = (cs_sel == cur_cs) ? S_SETUP : S_GAP;
            S_GAP:   if (phase_end_c) state_nxt = S_SETUP;
            S_SETUP: if (phase_end_c) state_nxt = S_HIGH;
            S_HIGH:  if (phase_end_c) state_nxt = S_LOW;
            S_LOW: begin
                if (phase_end_c) begin
                    if (bit_cnt == 4'd15) state_nxt = cur_hold ? S_HELD : S_IDLE;
                    else                  state_nxt = S_HIGH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Divider, bit counter and shift registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            cur_cs   <= '0;
            cur_hold <= 1'b0;
        end else begin
            if (state_nxt != state) div_cnt <= DIV_LOAD;
            else if (!phase_end_c)  div_cnt <= div_cnt - 1'b1;

            if (accept_c) begin
                tx_sr    <= tx_data;
                cur_cs   <= cs_sel;
                cur_hold <= hold;
                bit_cnt  <= '0;
            end else if (state == S_HIGH && state_nxt == S_LOW && bit_cnt != 4'd15) begin
                // Last bit stays on mosi through the trailing low phase.
                tx_sr <= {tx_sr[14:0], 1'b0};
            end

            if (state == S_LOW && phase_end_c) bit_cnt <= bit_cnt + 1'b1;

            // First HIGH cycle ends on the clk edge that raises sclk.
            if (state == S_HIGH && div_cnt == DIV_LOAD) rx_sr <= {rx_sr[14:0], spi_miso};
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            spi_sclk <= 1'b0;
            spi_cs_n <= '1;
            spi_mosi <= 1'b0;
        end else begin
            busy     <= active_c || (state == S_GAP);
            done     <= word_end_c;
            spi_sclk <= (state == S_HIGH);
            spi_cs_n <= cs_n_c;
            spi_mosi <= active_c && tx_sr[15];
            if (word_end_c) rx_data <= rx_sr;
        end
    end

endmodule
